// File: rtl/sp_req_ctrl_if.sv
// Request, response and RAM-pin bundle for sp_req_ctrl.
// slave = controller view, master = requester/RAM-side view.
interface sp_req_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          mem_cs;
  logic          mem_we;
  logic          mem_oe;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_cs, mem_we, mem_oe, mem_addr, mem_wdata, busy
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_cs, mem_we, mem_oe, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sp_req_ctrl.sv
// In-order request FIFO plus single-access FSM driving a single-port RAM.
// Optional out-of-range address filtering: define SP_REQ_CTRL_RANGE_CHECK_EN.
module sp_req_ctrl #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_DEPTH  = 256
) (
  input logic          clk,
  input logic          rst,
  sp_req_ctrl_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
`ifdef SP_REQ_CTRL_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [FIFO_DEPTH-1:0] fifo_we_q;
  logic [AW-1:0]         fifo_addr_q  [FIFO_DEPTH];
  logic [DW-1:0]         fifo_wdata_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  req_ready_q, busy_q;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0]         rsp_rdata_q, rsp_rdata_d;
  logic                  mem_cs_q, mem_cs_d, mem_we_q, mem_we_d, mem_oe_q, mem_oe_d;
  logic [AW-1:0]         mem_addr_q, mem_addr_d;
  logic [DW-1:0]         mem_wdata_q, mem_wdata_d;
  logic                  push_s, pop_s, head_oor_s;

  assign push_s     = bus.req_valid && req_ready_q;
  assign pop_s      = (state_q == S_IDLE) && (count_q != {CW{1'b0}});
  assign count_d    = count_q + CW'(push_s) - CW'(pop_s);
  assign head_oor_s = RANGE_CHK && (fifo_addr_q[rd_ptr_q] >= AW'(MEM_DEPTH));

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_we_q[wr_ptr_q]    <= bus.req_we;
      fifo_addr_q[wr_ptr_q]  <= bus.req_addr;
      fifo_wdata_q[wr_ptr_q] <= bus.req_wdata;
    end
  end

  // Next-state and next-output logic of the access FSM
  always_comb begin
    state_d     = state_q;
    mem_cs_d    = mem_cs_q;
    mem_we_d    = mem_we_q;
    mem_oe_d    = mem_oe_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (pop_s) begin
          mem_addr_d  = fifo_addr_q[rd_ptr_q];
          mem_wdata_d = fifo_wdata_q[rd_ptr_q];
          if (!head_oor_s) begin
            mem_cs_d = 1'b1;
            mem_we_d = fifo_we_q[rd_ptr_q];
            state_d  = S_ISSUE;
          end else if (fifo_we_q[rd_ptr_q]) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      // A dropped write reaches here with cs low and simply retires
      S_ISSUE: begin
        mem_cs_d = 1'b0;
        mem_we_d = 1'b0;
        if (mem_cs_q && !mem_we_q) begin
          mem_oe_d = 1'b1;
          state_d  = S_CAPTURE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CAPTURE: begin
        rsp_rdata_d = bus.mem_rdata;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        mem_oe_d    = 1'b0;
        state_d     = S_RESP;
      end
      // Entering without a valid response means an out-of-range read
      S_RESP: begin
        if (!rsp_valid_q) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = {DW{1'b0}};
          rsp_err_d   = 1'b1;
          state_d     = S_RESP;
        end else if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        mem_cs_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_oe_d    = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State, pointers and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DW{1'b0}};
      rsp_err_q   <= 1'b0;
      mem_cs_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      req_ready_q <= (count_d != CW'(FIFO_DEPTH));
      busy_q      <= (count_d != {CW{1'b0}}) || (state_d != S_IDLE);
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_cs_q    <= mem_cs_d;
      mem_we_q    <= mem_we_d;
      mem_oe_q    <= mem_oe_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_oe    = mem_oe_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_sp_req_ctrl.sv
// Randomized self-checking bench for sp_req_ctrl with a RAM model and an
// in-order response scoreboard derived from accepted requests.
module tb_sp_req_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int MEM_DEPTH = 256;
`ifdef SP_REQ_CTRL_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sp_req_ctrl_if #(.DW(DW), .AW(AW)) bus ();

  sp_req_ctrl #(.DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // RAM model: registered read data one cycle after the read edge
  logic [DW-1:0] ram [MEM_DEPTH];
  always @(posedge clk) begin
    if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    else if (bus.mem_cs) bus.mem_rdata <= ram[bus.mem_addr[7:0]];
  end

  // Scoreboard: expected {err, data} per accepted read, in acceptance order
  logic [DW-1:0] ref_mem [MEM_DEPTH];
  logic [DW:0]   exp_q [$];
  int  n_rsp = 0;
  int  cs_cycles = 0;
  int  proto_err = 0;
  logic cs_prev = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      cs_prev = 1'b0;
    end else begin
      if (bus.req_valid && bus.req_ready) begin
        if (RC && (bus.req_addr >= AW'(MEM_DEPTH))) begin
          if (!bus.req_we) exp_q.push_back({1'b1, {DW{1'b0}}});
        end else if (bus.req_we) begin
          ref_mem[bus.req_addr[7:0]] = bus.req_wdata;
        end else begin
          exp_q.push_back({1'b0, ref_mem[bus.req_addr[7:0]]});
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        logic has;
        logic [DW:0] e;
        has = (exp_q.size() != 0);
        check_eq("rsp_pending", 64'(has), 64'd1);
        if (has) begin
          e = exp_q.pop_front();
          check_eq("rsp_data", 64'({bus.rsp_err, bus.rsp_rdata}), 64'(e));
        end
        n_rsp++;
      end
      if (bus.mem_cs && cs_prev) proto_err++;
      if (bus.mem_we && !bus.mem_cs) proto_err++;
      if (bus.mem_oe && bus.mem_cs) proto_err++;
      if (bus.mem_cs) cs_cycles++;
      cs_prev = bus.mem_cs;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input bit rnd_rdy);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    while (!bus.req_ready && n < 200) begin
      if (rnd_rdy) bus.rsp_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    if (!bus.req_ready) check_eq("send_timeout", 64'(n), 64'd0);
    else tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || bus.busy) && n < 500) begin
      tick();
      n++;
    end
    check_eq("drain_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rsp0, acc_n, cs_snap, rd_cnt, vcnt;
    bit acc, oe_seen;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ctrl", 64'({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_cs,
                              bus.mem_we, bus.mem_oe, bus.busy}), 64'd0);
    check_eq("rst_rdata", 64'(bus.rsp_rdata), 64'd0);
    check_eq("rst_maddr", 64'(bus.mem_addr), 64'd0);
    check_eq("rst_mwdata", 64'(bus.mem_wdata), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("ready_at_deassert", 64'(bus.req_ready), 64'd0);
    tick();
    check_eq("ready_after_deassert", 64'({bus.req_ready, bus.busy}), 64'b10);

    // Single write then read with exact latency
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'd5; bus.req_wdata = 32'hDEADBEEF;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_eq("wr_issue", 64'({bus.mem_cs, bus.mem_we, bus.mem_oe}), 64'b110);
    check_eq("wr_addr", 64'(bus.mem_addr), 64'd5);
    check_eq("wr_data", 64'(bus.mem_wdata), 64'hDEADBEEF);
    tick();
    check_eq("wr_done", 64'({bus.mem_cs, bus.mem_we, bus.busy}), 64'd0);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'd5;
    tick();
    bus.req_valid = 1'b0;
    tick();
    check_eq("rd_issue", 64'({bus.mem_cs, bus.mem_we, bus.mem_oe, bus.rsp_valid}), 64'b1000);
    tick();
    check_eq("rd_capture", 64'({bus.mem_cs, bus.mem_oe, bus.rsp_valid}), 64'b010);
    tick();
    check_eq("rd_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.mem_oe}), 64'b100);
    check_eq("rd_rdata", 64'(bus.rsp_rdata), 64'hDEADBEEF);
    tick();

    // Alternating writes/reads to 0..4 with pointer wrap
    rsp0 = n_rsp;
    for (int a = 0; a < 5; a++) begin
      send(1'b1, AW'(a), DW'(32'h100 + a), 1'b0);
      send(1'b0, AW'(a), '0, 1'b0);
    end
    drain();
    check_eq("wrap_rsp_count", 64'(n_rsp - rsp0), 64'd5);

    for (int a = 5; a < 16; a++) send(1'b1, AW'(a), DW'($urandom), 1'b0);
    drain();

    // FIFO full with response held back
    bus.rsp_ready = 1'b0;
    acc_n = 0;
    cs_snap = 0;
    rsp0 = n_rsp;
    for (int c = 0; c < 20; c++) begin
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = AW'(acc_n);
      acc = bus.req_ready;
      tick();
      if (acc) acc_n++;
      if (c == 8) cs_snap = cs_cycles;
    end
    bus.req_valid = 1'b0;
    check_eq("full_accepts", 64'(acc_n), 64'(FIFO_DEPTH + 1));
    check_eq("full_ready", 64'(bus.req_ready), 64'd0);
    check_eq("hold_no_cs", 64'(cs_cycles - cs_snap), 64'd0);
    check_eq("hold_rsp", 64'({bus.rsp_valid, bus.rsp_rdata}), 64'({1'b1, 32'h100}));
    drain();
    check_eq("full_rsp_count", 64'(n_rsp - rsp0), 64'(FIFO_DEPTH + 1));

    // Randomized traffic with random back-pressure
    rsp0 = n_rsp;
    rd_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      acc = 1'($urandom_range(0, 1));
      if (!acc) rd_cnt++;
      send(acc, AW'($urandom_range(0, 15)), DW'($urandom), 1'b1);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
    check_eq("rand_rsp_count", 64'(n_rsp - rsp0), 64'(rd_cnt));

    // Reset during CAPTURE discards the read
    bus.rsp_ready = 1'b0;
    rsp0 = n_rsp;
    send(1'b0, 32'd3, '0, 1'b0);
    oe_seen = 1'b0;
    for (int i = 0; i < 10 && !oe_seen; i++) begin
      if (bus.mem_oe) oe_seen = 1'b1;
      else tick();
    end
    check_eq("capture_reached", 64'(oe_seen), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("midrst_outs", 64'({bus.mem_oe, bus.rsp_valid, bus.mem_cs, bus.busy, bus.req_ready}), 64'd0);
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid) vcnt++;
    end
    check_eq("midrst_no_rsp", 64'(vcnt), 64'd0);
    check_eq("midrst_rsp_count", 64'(n_rsp - rsp0), 64'd0);

`ifdef SP_REQ_CTRL_RANGE_CHECK_EN
    // Out-of-range read errors without touching the RAM; write is dropped
    bus.rsp_ready = 1'b0;
    cs_snap = cs_cycles;
    send(1'b0, 32'd300, '0, 1'b0);
    check_eq("oor_lat0", 64'(bus.rsp_valid), 64'd0);
    tick();
    check_eq("oor_lat1", 64'(bus.rsp_valid), 64'd0);
    tick();
    check_eq("oor_rsp", 64'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 64'({2'b11, 32'h0}));
    drain();
    send(1'b1, 32'd400, 32'h55AA55AA, 1'b0);
    drain();
    check_eq("oor_no_cs", 64'(cs_cycles - cs_snap), 64'd0);
    send(1'b0, 32'd7, '0, 1'b0);
    drain();
`endif

    check_eq("protocol", 64'(proto_err), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
